serial_parity_framer: RTL

//  Serial parity checker for framed bitstreams, LSB first, one bit per accepted cycle.

---
 rtl/parity_framer_pkg.sv | 13 +
 rtl/parity_bit_counter.sv | 54 +++++
 rtl/serial_parity_framer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/parity_framer_pkg.sv
// Shared state encodings and sizing helper for the serial parity framer.
package parity_framer_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DATA = 2'd1;
  localparam logic [1:0] PAR  = 2'd2;

  // Bits needed to hold 0..frame_bits inclusive.
  function automatic int cnt_width(input int frame_bits);
    return (frame_bits < 1) ? 1 : $clog2(frame_bits + 1);
  endfunction

endpackage

// File: rtl/parity_bit_counter.sv
// Data-bit counter for one frame: load-1 on SOF, increment per data bit, clear after parity.
// tc flags the update that makes the count reach FRAME_BITS (last data bit accepted).
module parity_bit_counter
  import parity_framer_pkg::*;
#(
  parameter int FRAME_BITS = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load1,
  input  logic inc,
  input  logic clr,
  output logic tc
);

  localparam int CW = cnt_width(FRAME_BITS);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BITS - 1);
  localparam bit SINGLE_BIT = (FRAME_BITS == 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load1) begin
      count_d = CW'(1);
    end else if (inc && (count_q != CNT_FULL)) begin
      count_d = count_q + CW'(1);
    end
  end

  // A one-bit frame completes its data phase on the SOF bit itself.
  always_comb begin
    tc = 1'b0;
    if (!clr) begin
      if (load1) begin
        tc = SINGLE_BIT;
      end else if (inc) begin
        tc = (count_q == CNT_LAST);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serial_parity_framer.sv
// Serial LSB-first parity checker: FSM plus running-parity accumulator.
// Optional saturating error counter enabled by defining PARITY_ERR_CNT_EN.
module serial_parity_framer
  import parity_framer_pkg::*;
#(
  parameter int FRAME_BITS = 8,
  parameter bit ODD_PARITY = 1'b0
`ifdef PARITY_ERR_CNT_EN
  ,
  parameter int ERR_CNT_W  = 8
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_sof,
  input  logic in_bit,
  output logic even,
  output logic busy,
  output logic frame_done,
  output logic par_exp,
  output logic par_err,
  output logic frame_abort
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);

  logic [1:0] state_q, state_d;
  logic       even_q, even_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       par_exp_q, par_exp_d;
  logic       par_err_q, par_err_d;
  logic       abort_q, abort_d;
  logic       cnt_load1, cnt_inc, cnt_clr, cnt_tc;
  logic       exp_bit;

  parity_bit_counter #(
    .FRAME_BITS(FRAME_BITS)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load1(cnt_load1),
    .inc  (cnt_inc),
    .clr  (cnt_clr),
    .tc   (cnt_tc)
  );

  assign exp_bit = ODD_PARITY ? even_q : ~even_q;

  always_comb begin
    state_d   = state_q;
    even_d    = even_q;
    done_d    = 1'b0;
    abort_d   = 1'b0;
    par_exp_d = par_exp_q;
    par_err_d = par_err_q;
    cnt_load1 = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    if (in_valid) begin
      // SOF always wins, including on the parity-bit cycle.
      if (in_sof) begin
        abort_d   = (state_q != IDLE);
        cnt_load1 = 1'b1;
        even_d    = ~in_bit;
        state_d   = cnt_tc ? PAR : DATA;
      end else begin
        case (state_q)
          DATA: begin
            cnt_inc = 1'b1;
            even_d  = even_q ^ in_bit;
            if (cnt_tc) begin
              state_d = PAR;
            end
          end
          PAR: begin
            cnt_clr   = 1'b1;
            par_exp_d = exp_bit;
            par_err_d = in_bit ^ exp_bit;
            done_d    = 1'b1;
            even_d    = 1'b1;
            state_d   = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      even_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      par_exp_q <= 1'b0;
      par_err_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      even_q    <= even_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      par_exp_q <= par_exp_d;
      par_err_q <= par_err_d;
      abort_q   <= abort_d;
    end
  end

  assign even        = even_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign par_exp     = par_exp_q;
  assign par_err     = par_err_q;
  assign frame_abort = abort_q;

`ifdef PARITY_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Updates alongside frame_done so the count already includes the reported frame.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (done_d && par_err_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule
